// File: rtl/node_select_multi.sv
`default_nettype none
// ============================================================================
// Module   : node_select_multi
// Purpose  : Collects NUM_PICK distinct node indices from the switches, one
//            per go press, and reports progress/errors on six HEX digits.
// Revision : 1.0 - initial release
// ============================================================================
module node_select_multi #(
    parameter int NODE_W   = 5,
    parameter int NUM_PICK = 2,
    parameter int MIN_PICK = 1,
    parameter int NO_DUP   = 1
) (
    input  logic                         clk,
    input  logic                         program_reset,
    input  logic                         start_process,
    input  logic                         go,
    input  logic                         input_over,
    input  logic [9:0]                   data_in,
    input  logic [NODE_W-1:0]            numNodes,
    output logic                         end_process,
    output logic [NUM_PICK*NODE_W-1:0]   picks,
    output logic [3:0]                   pick_count,
    output logic [NUM_PICK-1:0]          pick_valid,
    output logic [6:0]                   h0,
    output logic [6:0]                   h1,
    output logic [6:0]                   h2,
    output logic [6:0]                   h3,
    output logic [6:0]                   h4,
    output logic [6:0]                   h5,
    output logic [2:0]                   cs
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_CLEAR   = 3'd1;
    localparam logic [2:0] c_PROMPT  = 3'd2;
    localparam logic [2:0] c_JUDGE   = 3'd3;
    localparam logic [2:0] c_ACCEPT  = 3'd4;
    localparam logic [2:0] c_INVALID = 3'd5;
    localparam logic [2:0] c_DONE    = 3'd6;

    localparam logic [6:0] c_BLANK = 7'h7F;
    localparam logic [6:0] c_SEG_P = 7'h0C;
    localparam logic [6:0] c_SEG_E = 7'h06;
    localparam logic [6:0] c_SEG_R = 7'h2F;
    localparam logic [6:0] c_SEG_D = 7'h21;
    localparam logic [6:0] c_SEG_N = 7'h2B;

    logic [2:0]                 r_state;
    logic                       r_go_q;
    logic [9:0]                 r_cand;
    logic [NUM_PICK*NODE_W-1:0] r_picks;
    logic [NUM_PICK-1:0]        r_pick_valid;
    logic [3:0]                 r_pick_count;
    logic [NODE_W-1:0]          r_last;
    logic [6:0]                 r_h0, r_h1, r_h2, r_h3, r_h4, r_h5;

    logic                       w_go_edge;
    logic                       w_hi_zero;
    logic                       w_in_range;
    logic                       w_dup;
    logic                       w_ok;
    logic [NODE_W-1:0]          w_shown;
    logic [3:0]                 w_tens;
    logic [3:0]                 w_units;
    logic [3:0]                 w_h4_val;
    logic [6:0]                 w_h0_nxt, w_h1_nxt, w_h2_nxt, w_h3_nxt, w_h4_nxt, w_h5_nxt;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        case (d)
            4'd0:    f_seg = 7'h40;
            4'd1:    f_seg = 7'h79;
            4'd2:    f_seg = 7'h24;
            4'd3:    f_seg = 7'h30;
            4'd4:    f_seg = 7'h19;
            4'd5:    f_seg = 7'h12;
            4'd6:    f_seg = 7'h02;
            4'd7:    f_seg = 7'h78;
            4'd8:    f_seg = 7'h00;
            4'd9:    f_seg = 7'h10;
            default: f_seg = c_BLANK;
        endcase
    endfunction

    assign w_go_edge  = go & ~r_go_q;
    assign w_hi_zero  = ((r_cand >> NODE_W) == 10'd0);
    assign w_in_range = (r_cand[NODE_W-1:0] < numNodes);

    always_comb begin
        w_dup = 1'b0;
        for (int k = 0; k < NUM_PICK; k++) begin
            if (r_pick_valid[k] && (r_picks[k*NODE_W +: NODE_W] == r_cand[NODE_W-1:0]))
                w_dup = 1'b1;
        end
    end

    assign w_ok = w_hi_zero && w_in_range && !((NO_DUP != 0) && w_dup);

    // In DONE the last accepted pick is echoed; otherwise the live switches.
    assign w_shown  = (r_state == c_DONE) ? r_last : data_in[NODE_W-1:0];
    assign w_tens   = 4'((w_shown / NODE_W'(10)) % NODE_W'(10));
    assign w_units  = 4'(w_shown % NODE_W'(10));
    assign w_h4_val = (r_state == c_DONE) ? r_pick_count : r_pick_count + 4'd1;

    always_comb begin
        w_h0_nxt = c_BLANK;
        w_h1_nxt = c_BLANK;
        w_h2_nxt = c_BLANK;
        w_h3_nxt = c_BLANK;
        w_h4_nxt = c_BLANK;
        w_h5_nxt = c_BLANK;
        if (r_state != c_IDLE && r_state != c_CLEAR) begin
            w_h5_nxt = c_SEG_P;
            w_h4_nxt = f_seg(w_h4_val);
            if (r_state == c_INVALID) begin
                w_h3_nxt = c_SEG_E;
                w_h2_nxt = c_SEG_R;
            end else if (r_state == c_DONE) begin
                w_h3_nxt = c_SEG_D;
                w_h2_nxt = c_SEG_N;
            end
            if (r_state == c_PROMPT || r_state == c_INVALID || r_state == c_DONE) begin
                w_h1_nxt = f_seg(w_tens);
                w_h0_nxt = f_seg(w_units);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!program_reset) begin
            r_state      <= c_IDLE;
            r_go_q       <= 1'b0;
            r_cand       <= 10'd0;
            r_picks      <= '0;
            r_pick_valid <= '0;
            r_pick_count <= 4'd0;
            r_last       <= '0;
            r_h0         <= c_BLANK;
            r_h1         <= c_BLANK;
            r_h2         <= c_BLANK;
            r_h3         <= c_BLANK;
            r_h4         <= c_BLANK;
            r_h5         <= c_BLANK;
        end else begin
            r_go_q <= go;
            r_h0   <= w_h0_nxt;
            r_h1   <= w_h1_nxt;
            r_h2   <= w_h2_nxt;
            r_h3   <= w_h3_nxt;
            r_h4   <= w_h4_nxt;
            r_h5   <= w_h5_nxt;
            // Dropping start_process abandons any entry in flight; picks stay.
            if (r_state != c_IDLE && !start_process) begin
                r_state <= c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (start_process)
                            r_state <= c_CLEAR;
                    end
                    c_CLEAR: begin
                        r_picks      <= '0;
                        r_pick_valid <= '0;
                        r_pick_count <= 4'd0;
                        r_state      <= c_PROMPT;
                    end
                    c_PROMPT, c_INVALID: begin
                        if (w_go_edge) begin
                            r_cand  <= data_in;
                            r_state <= c_JUDGE;
                        end else if (input_over && (r_pick_count >= 4'(MIN_PICK))) begin
                            r_state <= c_DONE;
                        end
                    end
                    c_JUDGE: begin
                        r_state <= w_ok ? c_ACCEPT : c_INVALID;
                    end
                    c_ACCEPT: begin
                        for (int k = 0; k < NUM_PICK; k++) begin
                            if (r_pick_count == 4'(k)) begin
                                r_picks[k*NODE_W +: NODE_W] <= r_cand[NODE_W-1:0];
                                r_pick_valid[k]             <= 1'b1;
                            end
                        end
                        r_pick_count <= r_pick_count + 4'd1;
                        r_last       <= r_cand[NODE_W-1:0];
                        r_state      <= ((r_pick_count + 4'd1) == 4'(NUM_PICK)) ? c_DONE : c_PROMPT;
                    end
                    c_DONE: begin
                        r_state <= c_DONE;
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign end_process = (r_state == c_DONE);
    assign picks       = r_picks;
    assign pick_count  = r_pick_count;
    assign pick_valid  = r_pick_valid;
    assign cs          = r_state;
    assign h0          = r_h0;
    assign h1          = r_h1;
    assign h2          = r_h2;
    assign h3          = r_h3;
    assign h4          = r_h4;
    assign h5          = r_h5;

endmodule
`default_nettype wire
